// File: rtl/axis_cic_interpolator_if.sv
// AXI-Stream sample channel used on both sides of the CIC interpolator.
interface axis_cic_interpolator_if #(
   parameter int WIDTH = 16
);
   logic signed [WIDTH-1:0] tdata;
   logic                    tvalid;
   logic                    tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_cic_interpolator.sv
// CIC interpolator: combs at input rate, zero-stuff by RATE, integrators at output rate,
// gain removed by an exact arithmetic shift so DC passes unchanged.
module axis_cic_interpolator #(
   parameter int WIDTH      = 16,
   parameter int RATE       = 16,
   parameter int STAGES     = 3,
   parameter int DIFF_DELAY = 1
) (
   input  logic                     aclk,
   input  logic                     arst,
   axis_cic_interpolator_if.slave   s_axis_data,
   axis_cic_interpolator_if.master  m_axis_data,
   output logic                     underrun
);
   localparam int LOG_R  = $clog2(RATE);
   localparam int GROWTH = STAGES * $clog2(RATE * DIFF_DELAY) - LOG_R;
   localparam int IW     = WIDTH + GROWTH;

   logic        [LOG_R-1:0] phase_q, phase_d;
   logic signed [IW-1:0]    dly_q   [STAGES][DIFF_DELAY];
   logic signed [IW-1:0]    integ_q [STAGES];
   logic signed [IW-1:0]    integ_d [STAGES];
   logic signed [IW-1:0]    comb_in [STAGES];
   logic signed [IW-1:0]    comb_acc, integ_acc;
   logic signed [WIDTH-1:0] tdata_q, tdata_d;
   logic                    tvalid_q, underrun_q, underrun_d, started_q;
   logic                    step, frame_start, advance, accept;

   assign step        = !tvalid_q || m_axis_data.tready;
   assign frame_start = (phase_q == '0);
   assign advance     = step && (!frame_start || s_axis_data.tvalid);
   assign accept      = advance && frame_start;
   assign phase_d     = phase_q + LOG_R'(1);
   // Idle before the very first sample is startup, not starvation.
   assign underrun_d  = step && frame_start && !s_axis_data.tvalid && started_q;

   always_comb begin
      comb_acc = IW'(s_axis_data.tdata);
      for (int k = 0; k < STAGES; k++) begin
         comb_in[k] = comb_acc;
         comb_acc   = comb_acc - dly_q[k][DIFF_DELAY-1];
      end
      integ_acc = frame_start ? comb_acc : '0;
      for (int k = 0; k < STAGES; k++) begin
         integ_acc  = integ_acc + integ_q[k];
         integ_d[k] = integ_acc;
      end
      tdata_d = WIDTH'(integ_acc >>> GROWTH);
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         phase_q    <= '0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         underrun_q <= 1'b0;
         started_q  <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            integ_q[k] <= '0;
            for (int j = 0; j < DIFF_DELAY; j++) begin
               dly_q[k][j] <= '0;
            end
         end
      end else begin
         underrun_q <= underrun_d;
         if (accept) begin
            started_q <= 1'b1;
         end
         if (advance) begin
            phase_q  <= phase_d;
            tdata_q  <= tdata_d;
            tvalid_q <= 1'b1;
            for (int k = 0; k < STAGES; k++) begin
               integ_q[k] <= integ_d[k];
            end
            // Comb delay lines only move on real input samples.
            if (frame_start) begin
               for (int k = 0; k < STAGES; k++) begin
                  dly_q[k][0] <= comb_in[k];
                  for (int j = 1; j < DIFF_DELAY; j++) begin
                     dly_q[k][j] <= dly_q[k][j-1];
                  end
               end
            end
         end else if (step) begin
            tvalid_q <= 1'b0;
         end
      end
   end

   assign s_axis_data.tready = step && frame_start;
   assign m_axis_data.tdata  = tdata_q;
   assign m_axis_data.tvalid = tvalid_q;
   assign underrun           = underrun_q;
endmodule

// File: tb/tb_axis_cic_interpolator.sv
// Bench: small-config impulse table plus default-config scoreboard against a convolution model.
module tb_axis_cic_interpolator;
   localparam int RB     = 16;
   localparam int NB     = 3;
   localparam int MB     = 1;
   localparam int GB     = NB * $clog2(RB * MB) - $clog2(RB);
   localparam int HLEN_B = NB * (RB * MB - 1) + 1;
   localparam int NVEC   = 14;

   typedef struct {
      logic               s_tvalid;
      logic signed [15:0] s_tdata;
      logic               m_tready;
      logic               exp_tvalid;
      logic signed [15:0] exp_tdata;
      logic               exp_s_tready;
      logic               exp_underrun;
   } vec_t;

   logic aclk = 1'b0;
   logic arst_a = 1'b1;
   logic arst_b = 1'b1;
   logic underrun_a, underrun_b;

   axis_cic_interpolator_if #(.WIDTH(16)) s_a ();
   axis_cic_interpolator_if #(.WIDTH(16)) m_a ();
   axis_cic_interpolator_if #(.WIDTH(16)) s_b ();
   axis_cic_interpolator_if #(.WIDTH(16)) m_b ();

   axis_cic_interpolator #(.WIDTH(16), .RATE(4), .STAGES(2), .DIFF_DELAY(1)) dut_a (
      .aclk(aclk), .arst(arst_a), .s_axis_data(s_a), .m_axis_data(m_a), .underrun(underrun_a)
   );
   axis_cic_interpolator #(.WIDTH(16), .RATE(RB), .STAGES(NB), .DIFF_DELAY(MB)) dut_b (
      .aclk(aclk), .arst(arst_b), .s_axis_data(s_b), .m_axis_data(m_b), .underrun(underrun_b)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int failures = 0;
   vec_t tbl [NVEC];
   int hb [128];
   longint xin [$];
   int out_idx = 0;
   logic signed [15:0] last_out_b = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Impulse response of the whole interpolator at output rate: box(R*M) convolved N times.
   task automatic build_h();
      int h [128];
      int t [128];
      int len = 1;
      for (int k = 0; k < 128; k++) begin h[k] = 0; t[k] = 0; end
      h[0] = 1;
      for (int s = 0; s < NB; s++) begin
         for (int k = 0; k < len + RB * MB - 1; k++) begin
            int acc = 0;
            for (int u = 0; u < RB * MB; u++)
               if (k - u >= 0 && k - u < len) acc += h[k - u];
            t[k] = acc;
         end
         len += RB * MB - 1;
         for (int k = 0; k < len; k++) h[k] = t[k];
      end
      for (int k = 0; k < 128; k++) hb[k] = h[k];
   endtask

   function automatic logic signed [15:0] exp_b(input int n);
      longint y = 0;
      for (int i = n / RB; i >= 0; i--) begin
         int j = n - i * RB;
         if (j >= HLEN_B) break;
         if (i < xin.size()) y += xin[i] * longint'(hb[j]);
      end
      y = y >>> GB;
      return y[15:0];
   endfunction

   always @(negedge aclk) begin
      if (!arst_b) begin
         if (s_b.tvalid && s_b.tready) xin.push_back(longint'(s_b.tdata));
         if (m_b.tvalid && m_b.tready) begin
            chk($sformatf("sb_out[%0d]", out_idx), longint'(m_b.tdata), longint'(exp_b(out_idx)));
            last_out_b = m_b.tdata;
            out_idx++;
         end
      end
   end

   task automatic run_table_a(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         s_a.tvalid  = tbl[i].s_tvalid;
         s_a.tdata   = tbl[i].s_tdata;
         m_a.tready  = tbl[i].m_tready;
         @(posedge aclk); #1;
         chk($sformatf("%s_tvalid[%0d]", tag, i), longint'(m_a.tvalid), longint'(tbl[i].exp_tvalid));
         chk($sformatf("%s_tdata[%0d]", tag, i), longint'(m_a.tdata), longint'(tbl[i].exp_tdata));
         chk($sformatf("%s_s_tready[%0d]", tag, i), longint'(s_a.tready), longint'(tbl[i].exp_s_tready));
         chk($sformatf("%s_underrun[%0d]", tag, i), longint'(underrun_a), longint'(tbl[i].exp_underrun));
      end
   endtask

   task automatic reset_b();
      arst_b = 1'b1;
      @(posedge aclk); #1;
      xin.delete();
      out_idx = 0;
      arst_b = 1'b0;
   endtask

   task automatic wait_phase0_b(input string tag);
      int found = 0;
      for (int c = 0; c < 40; c++) begin
         s_b.tdata = 16'($urandom);
         @(posedge aclk); #1;
         if (s_b.tready) begin found = 1; break; end
      end
      chk(tag, found, 1);
   endtask

   task automatic drive_dc_b(input string tag, input logic signed [15:0] val, input int n);
      int acc = 0;
      s_b.tvalid = 1'b1;
      s_b.tdata  = val;
      for (int c = 0; c < n * RB * 2 && acc < n; c++) begin
         @(negedge aclk);
         if (s_b.tvalid && s_b.tready) acc++;
         @(posedge aclk); #1;
      end
      chk(tag, acc, n);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic signed [15:0] td;

      // s_tvalid s_tdata m_tready | tvalid tdata s_tready underrun   (RATE=4, N=2, GROWTH=2)
      tbl[0]  = '{1'b1, 16'sd4, 1'b1, 1'b1, 16'sd1, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 16'sd0, 1'b1, 1'b1, 16'sd2, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 16'sd0, 1'b1, 1'b1, 16'sd3, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 16'sd0, 1'b1, 1'b1, 16'sd4, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 16'sd0, 1'b1, 1'b1, 16'sd3, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 16'sd0, 1'b1, 1'b1, 16'sd2, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 16'sd0, 1'b1, 1'b1, 16'sd1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 16'sd0, 1'b1, 1'b1, 16'sd0, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 16'sd0, 1'b1, 1'b1, 16'sd0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 16'sd0, 1'b1, 1'b1, 16'sd0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 16'sd0, 1'b0, 1'b1, 16'sd0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 16'sd0, 1'b1, 1'b1, 16'sd0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 16'sd0, 1'b1, 1'b1, 16'sd0, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 16'sd0, 1'b1, 1'b0, 16'sd0, 1'b1, 1'b1};

      build_h();
      s_a.tvalid = 1'b0; s_a.tdata = '0; m_a.tready = 1'b1;
      s_b.tvalid = 1'b0; s_b.tdata = '0; m_b.tready = 1'b1;

      @(posedge aclk); #1;
      chk("rst_a_tvalid", longint'(m_a.tvalid), 0);
      chk("rst_a_tdata", longint'(m_a.tdata), 0);
      chk("rst_a_s_tready", longint'(s_a.tready), 1);
      chk("rst_b_tvalid", longint'(m_b.tvalid), 0);
      chk("rst_b_underrun", longint'(underrun_b), 0);
      arst_a = 1'b0;
      arst_b = 1'b0;

      // Impulse through the small configuration
      run_table_a("imp", NVEC);

      // Reset mid-frame, then the impulse must replay identically
      arst_a = 1'b1; @(posedge aclk); #1; arst_a = 1'b0;
      run_table_a("pre", 3);
      arst_a = 1'b1;
      #1;
      chk("arst_async_tvalid", longint'(m_a.tvalid), 0);
      chk("arst_async_tdata", longint'(m_a.tdata), 0);
      chk("arst_async_s_tready", longint'(s_a.tready), 1);
      @(posedge aclk); #1;
      arst_a = 1'b0;
      chk("arst_rel_tvalid", longint'(m_a.tvalid), 0);
      chk("arst_rel_s_tready", longint'(s_a.tready), 1);
      run_table_a("imp2", NVEC);

      // DC 1000, defaults
      reset_b();
      s_b.tvalid = 1'b1; s_b.tdata = 16'sd1000; m_b.tready = 1'b1;
      cnt = 0;
      repeat (160) begin
         @(posedge aclk); #1;
         if (s_b.tready) cnt++;
      end
      chk("dc_s_tready_count", cnt, 10);
      chk("dc_last_out", longint'(last_out_b), 1000);

      // Full-scale DC in both polarities
      reset_b();
      m_b.tready = 1'b1;
      drive_dc_b("fs_neg_accepts", -16'sd32768, 8);
      chk("fs_neg_out", longint'(last_out_b), -32768);
      drive_dc_b("fs_pos_accepts", 16'sd32767, 8);
      chk("fs_pos_out", longint'(last_out_b), 32767);

      // Backpressure held for 5 cycles at phase 3
      reset_b();
      s_b.tvalid = 1'b1; m_b.tready = 1'b1;
      wait_phase0_b("bp_phase0_found");
      repeat (3) begin
         s_b.tdata = 16'($urandom);
         @(posedge aclk); #1;
      end
      td = m_b.tdata;
      chk("bp_tvalid_before", longint'(m_b.tvalid), 1);
      m_b.tready = 1'b0;
      repeat (5) begin
         @(posedge aclk); #1;
         chk("bp_tdata_hold", longint'(m_b.tdata), longint'(td));
         chk("bp_tvalid_hold", longint'(m_b.tvalid), 1);
         chk("bp_s_tready", longint'(s_b.tready), 0);
      end
      m_b.tready = 1'b1;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge aclk); #1;
         cnt++;
         if (s_b.tready) break;
      end
      chk("bp_edges_to_frame_end", cnt, 13);
      repeat (40) begin
         s_b.tdata = 16'($urandom);
         @(posedge aclk); #1;
      end

      // Underrun: none at startup idle, three pulses after a 3-cycle gap
      reset_b();
      s_b.tvalid = 1'b0; m_b.tready = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(posedge aclk); #1;
         if (underrun_b) cnt++;
      end
      chk("ur_startup_pulses", cnt, 0);
      s_b.tvalid = 1'b1;
      wait_phase0_b("ur_phase0_found");
      s_b.tvalid = 1'b0;
      repeat (3) begin
         @(posedge aclk); #1;
         chk("ur_pulse", longint'(underrun_b), 1);
         chk("ur_tvalid_low", longint'(m_b.tvalid), 0);
      end
      s_b.tvalid = 1'b1;
      @(posedge aclk); #1;
      chk("ur_end_pulse", longint'(underrun_b), 0);
      chk("ur_end_tvalid", longint'(m_b.tvalid), 1);
      repeat (40) @(posedge aclk);
      #1;

      // Randomised traffic on both sides
      reset_b();
      for (int c = 0; c < 800; c++) begin
         s_b.tvalid = ($urandom_range(0, 9) < 8);
         s_b.tdata  = 16'($urandom);
         m_b.tready = ($urandom_range(0, 9) < 7);
         @(posedge aclk); #1;
      end
      chk("rand_outputs_seen", longint'(out_idx > 100), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
